// File: rtl/udp_tx_arbiter_if.sv
// Byte-wide AXI-Stream link with a 12-bit length sideband (tuser).
// master drives the payload; slave returns tready.
interface udp_tx_arbiter_if;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic [11:0] tuser;
    logic        tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UDP transmit path between
// the GPIO AXIS source (s0) and the MM2S DMA source (s1). A grant is held for
// a whole packet, followed by an inter-packet gap; per-source packet counters
// and sticky length-mismatch flags are kept alongside.
module udp_tx_arbiter #(
    parameter int unsigned IFG_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    udp_tx_arbiter_if.slave     s0_axis,
    udp_tx_arbiter_if.slave     s1_axis,
    udp_tx_arbiter_if.master    m_axis,
    input  logic                tx_ready,
    output logic [1:0]          grant,
    output logic [CNT_W-1:0]    pkt_cnt0,
    output logic [CNT_W-1:0]    pkt_cnt1,
    output logic [1:0]          len_err,
    input  logic                err_clr
);

    localparam int unsigned GapW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_s1_q, last_s1_d;   // 1: source 1 owned the previous packet
    logic [GapW-1:0]  gap_q, gap_d;
    logic [11:0]      byte_q, byte_d;
    logic [11:0]      len_q, len_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [1:0]       err_q, err_d;

    logic             xfer;
    logic             sel_s1;
    logic [7:0]       cur_data;
    logic             cur_valid;
    logic             cur_last;
    logic [11:0]      cur_user;
    logic             hs;
    logic [11:0]      eff_len;
    logic             pick_s1;

    assign xfer   = (state_q == StXfer);
    assign sel_s1 = grant_q[1];

    // Route the granted source onto the master port; everything idles at zero otherwise.
    always_comb begin
        cur_data  = 8'h00;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_user  = 12'h000;
        if (xfer) begin
            if (sel_s1) begin
                cur_data  = s1_axis.tdata;
                cur_valid = s1_axis.tvalid;
                cur_last  = s1_axis.tlast;
                cur_user  = s1_axis.tuser;
            end else begin
                cur_data  = s0_axis.tdata;
                cur_valid = s0_axis.tvalid;
                cur_last  = s0_axis.tlast;
                cur_user  = s0_axis.tuser;
            end
        end
    end

    assign m_axis.tdata   = cur_data;
    assign m_axis.tvalid  = cur_valid;
    assign m_axis.tlast   = cur_last;
    assign m_axis.tuser   = cur_user;
    assign s0_axis.tready = xfer & ~sel_s1 & m_axis.tready;
    assign s1_axis.tready = xfer &  sel_s1 & m_axis.tready;

    assign hs = cur_valid & m_axis.tready;

    // A single-beat packet has no captured length yet, so use the live tuser.
    assign eff_len = (byte_q == 12'd0) ? cur_user : len_q;

    // Next-state: arbitration, packet bookkeeping and gap countdown.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_s1_d = last_s1_q;
        gap_d     = gap_q;
        byte_d    = byte_q;
        len_d     = len_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        err_d     = err_clr ? 2'b00 : err_q;
        pick_s1   = 1'b0;

        case (state_q)
            StIdle: begin
                if (tx_ready && (s0_axis.tvalid || s1_axis.tvalid)) begin
                    if (s0_axis.tvalid && s1_axis.tvalid) begin
                        pick_s1 = ~last_s1_q;
                    end else begin
                        pick_s1 = s1_axis.tvalid;
                    end
                    grant_d = pick_s1 ? 2'b10 : 2'b01;
                    byte_d  = 12'd0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (hs) begin
                    if (byte_q == 12'd0) begin
                        len_d = cur_user;
                    end
                    byte_d = byte_q + 12'd1;
                    if (cur_last) begin
                        byte_d = 12'd0;
                        if (sel_s1) begin
                            cnt1_d = cnt1_q + CNT_W'(1);
                        end else begin
                            cnt0_d = cnt0_q + CNT_W'(1);
                        end
                        // A zero length disables the check; a new error beats err_clr.
                        if ((eff_len != 12'd0) && (eff_len != (byte_q + 12'd1))) begin
                            err_d[sel_s1] = 1'b1;
                        end
                        last_s1_d = sel_s1;
                        grant_d   = 2'b00;
                        if (IFG_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            gap_d   = GapW'(IFG_CYCLES);
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - GapW'(1);
                if (gap_q <= GapW'(1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            last_s1_q <= 1'b1;
            gap_q     <= '0;
            byte_q    <= 12'd0;
            len_q     <= 12'd0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_s1_q <= last_s1_d;
            gap_q     <= gap_d;
            byte_q    <= byte_d;
            len_q     <= len_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            err_q     <= err_d;
        end
    end

    assign grant    = grant_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign len_err  = err_q;

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single UDP/RMII transmit path between two byte-wide AXI-Stream requesters: the GPIO AXIS source and the MM2S DMA source.
- Sits in front of packet_gen's S_AXIS port and passes the winning source's data, last and 12-bit length (tuser) through unchanged.
- Holds a grant for a whole packet, then enforces a programmable inter-packet gap gated by the transmitter's TX_READY.
- Keeps per-source packet counters and sticky length-mismatch flags.

Parameters:
- IFG_CYCLES, 16, number of clk cycles idle after each packet's tlast beat before the next arbitration (0 = no gap).
- CNT_W, 16, width of the per-source packet counters.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous, active-low reset.
- s0_axis_tdata  input  8  source 0 (GPIO) data.
- s0_axis_tvalid  input  1  source 0 valid.
- s0_axis_tlast  input  1  source 0 last byte of packet.
- s0_axis_tuser  input  12  source 0 payload length in bytes; valid on the first beat.
- s0_axis_tready  output  1  source 0 ready.
- s1_axis_tdata / tvalid / tlast / tuser / tready: source 1 (DMA), same widths and directions as source 0.
- m_axis_tdata  output  8  to packet_gen S_AXIS_TDATA.
- m_axis_tvalid  output  1  to packet_gen S_AXIS_TVALID.
- m_axis_tlast  output  1  to packet_gen S_AXIS_TLAST.
- m_axis_tuser  output  12  to packet_gen S_AXIS_TUSER.
- m_axis_tready  input  1  from packet_gen S_AXIS_TREADY.
- tx_ready  input  1  transmitter idle indication (packet_gen TX_READY).
- grant  output  2  one-hot current owner; 00 when none.
- pkt_cnt0  output  CNT_W  count of completed source 0 packets.
- pkt_cnt1  output  CNT_W  count of completed source 1 packets.
- len_err  output  2  sticky per-source length mismatch flags.
- err_clr  input  1  synchronous pulse that clears len_err.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE, grant = 00, last_grant = source 1 (so source 0 wins the first tie).
  - Gap counter = 0, byte counter = 0, pkt_cnt0 = pkt_cnt1 = 0, len_err = 00.
  - All tready outputs and m_axis_tvalid = 0; m_axis_tdata, m_axis_tlast and m_axis_tuser = 0.
- States: IDLE, XFER, GAP.
- IDLE:
  - All tready = 0 and m_axis_tvalid = 0.
  - When tx_ready = 1 and at least one s*_tvalid = 1, pick a winner:
    - If only one source is valid, it wins.
    - If both are valid, the source other than last_grant wins.
  - Register grant and go to XFER on the next edge. Arbitration to the first beat offered on m_axis takes 1 cycle.
  - If tx_ready = 0, stay in IDLE regardless of valid.
- XFER (combinational mux, no added latency):
  - m_axis_tdata, tvalid, tlast and tuser come from the granted source.
  - The granted source's tready = m_axis_tready; the non-granted source's tready = 0.
  - Byte counter (12-bit) increments on each m_axis handshake and clears on tlast.
  - tuser is captured on the first beat of the packet.
  - On the tlast handshake:
    - Increment pkt_cnt of the granted source; the counter wraps from all-ones to 0.
    - If the captured tuser != 0 and the captured tuser != byte count including this beat, set len_err[granted]. Captured tuser = 0 disables the check.
    - last_grant <= granted source, grant <= 00.
    - Load the gap counter with IFG_CYCLES and go to GAP; if IFG_CYCLES = 0, go directly to IDLE.
  - A source dropping tvalid mid-packet does not release the grant; the arbiter waits.
  - tx_ready is ignored during XFER.
- GAP:
  - All tready = 0 and m_axis_tvalid = 0.
  - The gap counter decrements each cycle; at 0, go to IDLE.
  - The next arbitration happens in IDLE, so at least IFG_CYCLES + 1 cycles separate the tlast beat from the next first beat.
- Simultaneous events:
  - If err_clr and a new error occur in the same cycle, the set wins.
  - If both sources are valid at the same time, they alternate packet by packet; neither can starve the other.
- Reset mid-packet: the arbiter aborts immediately and returns to its reset state. Upstream sources must restart their packets.

Test Plan:
- Single-source transfer:
  - Stimulus: s0 sends a 4-byte packet (tuser = 4, bytes 11 22 33 44); tx_ready = 1; m_axis_tready = 1.
  - Required response: m_axis shows the same 4 beats with tlast on 44; grant = 01 during the packet; pkt_cnt0 = 1; len_err = 00.
- Round-robin fairness:
  - Stimulus: both sources continuously present 2-byte packets, with IFG_CYCLES = 16.
  - Required response: grant sequence is 01, 10, 01, 10; after 4 packets pkt_cnt0 = pkt_cnt1 = 2; each tlast beat and the next first beat are separated by 17 cycles or more.
- Backpressure and valid gaps:
  - Stimulus: m_axis_tready toggles every cycle and s1 deasserts tvalid for 3 cycles mid-packet.
  - Required response: no bytes are lost or duplicated; s0_axis_tready stays 0 throughout; the grant holds until tlast.
- Length mismatch:
  - Stimulus: s1 sends tuser = 10 but asserts tlast on byte 8.
  - Required response: len_err = 10 and it stays set through later good packets; an err_clr pulse returns it to 00.
- tx_ready gating:
  - Stimulus: tx_ready = 0 while s0 is valid.
  - Required response: no grant and s0_axis_tready = 0; grant = 01 one cycle after tx_ready rises.
- Reset mid-packet:
  - Stimulus: reset_n pulsed low after byte 2 of a 6-byte s0 packet.
  - Required response: m_axis_tvalid, tready and grant go to 0 at once (asynchronously); pkt_cnt0 = 0; the next packet arbitrates from IDLE.
